// File: rtl/eth_pkg.sv
// Shared definitions for the Ethernet RX frame arbiter: FSM encoding,
// abort filler byte and the saturating abort-counter helper.
package eth_pkg;

  typedef enum logic [1:0] {
    C_IDLE  = 2'd0,
    C_XFER  = 2'd1,
    C_ABORT = 2'd2,
    C_FLUSH = 2'd3
  } state_t;

  localparam logic [7:0]  C_ABORT_BYTE = 8'h00;
  localparam logic [15:0] C_ABORT_MAX  = 16'hFFFF;

  // Increment that sticks at all-ones instead of wrapping
  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    return (value == C_ABORT_MAX) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: finds the first set request bit
// searching upward from ptr+1 and wrapping modulo P_N.
module rr_pick
  import eth_pkg::*;
#(
  parameter int P_N  = 2,
  parameter int P_IW = 1
) (
  input  logic [P_N-1:0]  req,
  input  logic [P_IW-1:0] ptr,
  output logic [P_N-1:0]  onehot,
  output logic [P_IW-1:0] idx,
  output logic            any
);

  // Walk the offsets 1..P_N from the pointer; the first requester hit wins
  always_comb begin
    logic hit_s;
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    hit_s  = 1'b0;
    for (int off = 1; off <= P_N; off++) begin
      for (int i = 0; i < P_N; i++) begin
        hit_s     = !any && req[i] && (i == ((int'(ptr) + off) % P_N));
        onehot[i] = onehot[i] | hit_s;
        idx       = hit_s ? P_IW'(i) : idx;
        any       = any | hit_s;
      end
    end
  end

endmodule

// File: rtl/eth_rx_arbiter.sv
// Frame-atomic round-robin arbiter sharing one byte consumer between
// P_NUM_REQ frame streams, with a stall watchdog that aborts and flushes
// a frame whose owner stops supplying bytes.
module eth_rx_arbiter
  import eth_pkg::*;
#(
  parameter int P_NUM_REQ = 2,
  parameter int P_TIMEOUT = 1024
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [P_NUM_REQ*8-1:0] req_data,
  input  logic [P_NUM_REQ-1:0]   req_vld,
  input  logic [P_NUM_REQ-1:0]   req_last,
  output logic [P_NUM_REQ-1:0]   req_rdy,
  output logic [7:0]             out_data,
  output logic                   out_vld,
  output logic                   out_last,
  output logic                   out_err,
  input  logic                   out_rdy,
  output logic [P_NUM_REQ-1:0]   grant,
  output logic                   busy,
  output logic [15:0]            abort_cnt
);

  localparam int C_CNT_W = $clog2(P_TIMEOUT + 1);
  localparam int C_IDX_W = $clog2(P_NUM_REQ);
  localparam logic [C_CNT_W-1:0] C_STALL_LIM = C_CNT_W'(P_TIMEOUT - 1);

  state_t               state_r;
  logic [P_NUM_REQ-1:0] grant_r;
  logic [C_IDX_W-1:0]   rr_ptr_r;
  logic [C_CNT_W-1:0]   stall_cnt_r;
  logic [15:0]          abort_cnt_r;

  logic [7:0]           own_data_s;
  logic                 own_vld_s;
  logic                 own_last_s;
  logic                 stalling_s;
  logic                 timeout_s;
  logic [P_NUM_REQ-1:0] pick_onehot_s;
  logic [C_IDX_W-1:0]   pick_idx_s;
  logic                 pick_any_s;

  rr_pick #(
    .P_N  (P_NUM_REQ),
    .P_IW (C_IDX_W)
  ) u_pick (
    .req    (req_vld),
    .ptr    (rr_ptr_r),
    .onehot (pick_onehot_s),
    .idx    (pick_idx_s),
    .any    (pick_any_s)
  );

  assign grant      = grant_r;
  assign busy       = (state_r != C_IDLE);
  assign abort_cnt  = abort_cnt_r;
  assign own_vld_s  = |(req_vld & grant_r);
  assign own_last_s = |(req_last & grant_r);
  // Only XFER/FLUSH with the owner idle count as a stall; back-pressure never does
  assign stalling_s = ((state_r == C_XFER) || (state_r == C_FLUSH)) && !own_vld_s;
  assign timeout_s  = stalling_s && (stall_cnt_r == C_STALL_LIM);

  // One-hot mux of the owner's byte (grant is one-hot or zero)
  always_comb begin
    own_data_s = 8'h00;
    for (int i = 0; i < P_NUM_REQ; i++) begin
      own_data_s = own_data_s | (req_data[i*8 +: 8] & {8{grant_r[i]}});
    end
  end

  // Output steering: pass-through in XFER, filler beat in ABORT, sink in FLUSH
  always_comb begin
    out_data = 8'h00;
    out_vld  = 1'b0;
    out_last = 1'b0;
    out_err  = 1'b0;
    req_rdy  = '0;
    case (state_r)
      C_XFER: begin
        out_data = own_data_s;
        out_vld  = own_vld_s;
        out_last = own_last_s;
        req_rdy  = grant_r & {P_NUM_REQ{out_rdy}};
      end
      C_ABORT: begin
        out_data = C_ABORT_BYTE;
        out_vld  = 1'b1;
        out_last = 1'b1;
        out_err  = 1'b1;
      end
      C_FLUSH: begin
        req_rdy = grant_r;
      end
      default: begin
        out_vld = 1'b0;
      end
    endcase
  end

  // Arbitration FSM with grant, round-robin pointer, stall and abort counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= C_IDLE;
      grant_r     <= '0;
      rr_ptr_r    <= C_IDX_W'(P_NUM_REQ - 1);
      stall_cnt_r <= '0;
      abort_cnt_r <= 16'h0000;
    end else begin
      case (state_r)
        C_IDLE: begin
          stall_cnt_r <= '0;
          if (pick_any_s) begin
            grant_r  <= pick_onehot_s;
            rr_ptr_r <= pick_idx_s;
            state_r  <= C_XFER;
          end else begin
            grant_r <= '0;
          end
        end
        C_XFER: begin
          if (own_vld_s && out_rdy && own_last_s) begin
            state_r     <= C_IDLE;
            grant_r     <= '0;
            stall_cnt_r <= '0;
          end else if (timeout_s) begin
            state_r     <= C_ABORT;
            stall_cnt_r <= '0;
          end else if (own_vld_s) begin
            stall_cnt_r <= '0;
          end else begin
            stall_cnt_r <= stall_cnt_r + C_CNT_W'(1);
          end
        end
        C_ABORT: begin
          stall_cnt_r <= '0;
          if (out_rdy) begin
            abort_cnt_r <= sat_inc16(abort_cnt_r);
            state_r     <= C_FLUSH;
          end else begin
            state_r <= C_ABORT;
          end
        end
        C_FLUSH: begin
          // A second stall here gives up on the frame silently
          if ((own_vld_s && own_last_s) || timeout_s) begin
            state_r     <= C_IDLE;
            grant_r     <= '0;
            stall_cnt_r <= '0;
          end else if (own_vld_s) begin
            stall_cnt_r <= '0;
          end else begin
            stall_cnt_r <= stall_cnt_r + C_CNT_W'(1);
          end
        end
        default: begin
          state_r     <= C_IDLE;
          grant_r     <= '0;
          stall_cnt_r <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_eth_rx_arbiter.sv
// Scoreboard bench for eth_rx_arbiter: a cycle-based driver feeds per-
// requester beat queues, expected consumer beats are queued as stimulus is
// issued, and a monitor pops and compares every accepted output beat.
module tb_eth_rx_arbiter;

  localparam int N  = 2;
  localparam int TO = 16;

  typedef struct packed {
    logic       idle;
    logic [7:0] data;
    logic       last;
  } beat_t;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N*8-1:0] req_data;
  logic [N-1:0]   req_vld;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_rdy;
  logic [7:0]     out_data;
  logic           out_vld;
  logic           out_last;
  logic           out_err;
  logic           out_rdy;
  logic [N-1:0]   grant;
  logic           busy;
  logic [15:0]    abort_cnt;

  beat_t      rq[N][$];
  logic [9:0] exp_q[$];
  logic [N-1:0] gseen[$];
  bit         acc[N];
  bit         shown[N];
  int         n_cmp = 0;
  int         n_bad = 0;

  eth_rx_arbiter #(.P_NUM_REQ(N), .P_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req_data(req_data), .req_vld(req_vld),
    .req_last(req_last), .req_rdy(req_rdy), .out_data(out_data),
    .out_vld(out_vld), .out_last(out_last), .out_err(out_err),
    .out_rdy(out_rdy), .grant(grant), .busy(busy), .abort_cnt(abort_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, want);
    end
  endtask

  task automatic push_byte(input int i, input logic [7:0] d, input logic l, input bit to_out);
    rq[i].push_back({1'b0, d, l});
    if (to_out) exp_q.push_back({d, l, 1'b0});
  endtask

  task automatic push_idle(input int i, input int n);
    for (int k = 0; k < n; k++) rq[i].push_back({1'b1, 8'h00, 1'b0});
  endtask

  task automatic push_abort();
    exp_q.push_back({8'h00, 1'b1, 1'b1});
  endtask

  task automatic wait_done(input string name);
    int k;
    k = 0;
    while (k < 20000 && !(rq[0].size() == 0 && rq[1].size() == 0 &&
                          !busy && exp_q.size() == 0)) begin
      @(negedge clk);
      k++;
    end
    if (k >= 20000) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: not finished after %0d cycles, busy=%b pending=%0d",
               name, k, busy, exp_q.size());
    end
  endtask

  // Requester driver: one beat per requester, advanced after acceptance
  initial begin
    req_vld  = '0;
    req_last = '0;
    req_data = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) acc[i] = req_vld[i] && req_rdy[i];
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if ((acc[i] || shown[i]) && rq[i].size() > 0) void'(rq[i].pop_front());
        shown[i] = 1'b0;
        if (rq[i].size() > 0 && !rq[i][0].idle) begin
          req_vld[i]          = 1'b1;
          req_data[i*8 +: 8]  = rq[i][0].data;
          req_last[i]         = rq[i][0].last;
        end else begin
          req_vld[i]  = 1'b0;
          req_last[i] = 1'b0;
          shown[i]    = (rq[i].size() > 0);
        end
      end
    end
  end

  // Output monitor: every accepted beat must match the head of the scoreboard
  initial begin
    logic [9:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && out_vld && out_rdy) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL beat: unexpected data=%h last=%b err=%b", out_data, out_last, out_err);
        end else begin
          e = exp_q.pop_front();
          if ({out_data, out_last, out_err} !== e) begin
            n_bad++;
            $display("FAIL beat: got data=%h last=%b err=%b, want data=%h last=%b err=%b",
                     out_data, out_last, out_err, e[9:2], e[1], e[0]);
          end
        end
      end
    end
  end

  // Grant logger: records each new grant that follows an idle (zero) grant
  initial begin
    logic [N-1:0] prev;
    prev = '0;
    forever begin
      @(negedge clk);
      if (rst_n && grant != '0 && prev == '0) gseen.push_back(grant);
      prev = grant;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n   = 1'b0;
    out_rdy = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst grant", 32'(grant), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst out_vld", 32'(out_vld), 32'd0);
    chk("rst abort_cnt", 32'(abort_cnt), 32'd0);
    chk("rst req_rdy", 32'(req_rdy), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 4-byte frame on requester 0
    gseen.delete();
    @(posedge clk);
    #2;
    push_byte(0, 8'h11, 1'b0, 1'b1);
    push_byte(0, 8'h22, 1'b0, 1'b1);
    push_byte(0, 8'h33, 1'b0, 1'b1);
    push_byte(0, 8'h44, 1'b1, 1'b1);
    repeat (2) @(negedge clk);
    chk("t1 vld up", 32'(req_vld[0]), 32'd1);
    chk("t1 grant latency", 32'(grant), 32'd0);
    @(negedge clk);
    chk("t1 grant", 32'(grant), 32'd1);
    chk("t1 busy", 32'(busy), 32'd1);
    wait_done("t1");
    chk("t1 grant clear", 32'(grant), 32'd0);
    chk("t1 grant count", 32'(gseen.size()), 32'd1);

    // Both requesting continuously: pointer sits at 0 so requester 1 goes first
    gseen.delete();
    push_byte(0, 8'hA1, 1'b0, 1'b0); push_byte(0, 8'hA2, 1'b1, 1'b0);
    push_byte(0, 8'hA3, 1'b0, 1'b0); push_byte(0, 8'hA4, 1'b1, 1'b0);
    push_byte(1, 8'hB1, 1'b0, 1'b0); push_byte(1, 8'hB2, 1'b1, 1'b0);
    push_byte(1, 8'hB3, 1'b0, 1'b0); push_byte(1, 8'hB4, 1'b1, 1'b0);
    exp_q.push_back({8'hB1, 2'b00}); exp_q.push_back({8'hB2, 2'b10});
    exp_q.push_back({8'hA1, 2'b00}); exp_q.push_back({8'hA2, 2'b10});
    exp_q.push_back({8'hB3, 2'b00}); exp_q.push_back({8'hB4, 2'b10});
    exp_q.push_back({8'hA3, 2'b00}); exp_q.push_back({8'hA4, 2'b10});
    wait_done("t2");
    chk("t2 grant count", 32'(gseen.size()), 32'd4);
    if (gseen.size() == 4) begin
      chk("t2 grant0", 32'(gseen[0]), 32'd2);
      chk("t2 grant1", 32'(gseen[1]), 32'd1);
      chk("t2 grant2", 32'(gseen[2]), 32'd2);
      chk("t2 grant3", 32'(gseen[3]), 32'd1);
    end else begin
      $display("FAIL t2 grant list: got %0d grants, want 4", gseen.size());
      n_bad++;
    end

    // Stall after one byte: abort beat, then the rest is flushed silently
    push_byte(0, 8'hC1, 1'b0, 1'b1);
    push_abort();
    push_idle(0, 20);
    push_byte(0, 8'hC2, 1'b0, 1'b0);
    push_byte(0, 8'hC3, 1'b0, 1'b0);
    push_byte(0, 8'hC4, 1'b1, 1'b0);
    wait_done("t3");
    chk("t3 abort_cnt", 32'(abort_cnt), 32'd1);

    // Second stall inside FLUSH returns to IDLE; the trailing byte is a new 1-byte frame
    push_byte(0, 8'hD1, 1'b0, 1'b1);
    push_abort();
    push_idle(0, 40);
    push_byte(0, 8'hD2, 1'b1, 1'b1);
    wait_done("t4");
    chk("t4 abort_cnt", 32'(abort_cnt), 32'd2);

    // Long back-pressure never triggers the watchdog
    out_rdy = 1'b0;
    push_byte(1, 8'hE1, 1'b0, 1'b1);
    push_byte(1, 8'hE2, 1'b0, 1'b1);
    push_byte(1, 8'hE3, 1'b1, 1'b1);
    repeat (4) @(negedge clk);
    chk("t5 grant", 32'(grant), 32'd2);
    repeat (5000) @(negedge clk);
    chk("t5 out_vld", 32'(out_vld), 32'd1);
    chk("t5 out_data", 32'(out_data), 32'hE1);
    chk("t5 out_err", 32'(out_err), 32'd0);
    chk("t5 req_rdy", 32'(req_rdy), 32'd0);
    chk("t5 abort_cnt", 32'(abort_cnt), 32'd2);
    out_rdy = 1'b1;
    wait_done("t5");

    // Reset mid-frame while requester 1 owns the output
    out_rdy = 1'b0;
    push_byte(1, 8'hF1, 1'b0, 1'b0);
    push_byte(1, 8'hF2, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    chk("t6 grant before rst", 32'(grant), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6 rst grant", 32'(grant), 32'd0);
    chk("t6 rst busy", 32'(busy), 32'd0);
    chk("t6 rst out_vld", 32'(out_vld), 32'd0);
    chk("t6 rst abort_cnt", 32'(abort_cnt), 32'd0);
    rq[0].delete();
    rq[1].delete();
    repeat (2) @(negedge clk);
    rst_n   = 1'b1;
    out_rdy = 1'b1;
    gseen.delete();
    push_byte(0, 8'h5A, 1'b1, 1'b1);
    push_byte(1, 8'h6B, 1'b1, 1'b1);
    wait_done("t6");
    chk("t6 grant count", 32'(gseen.size()), 32'd2);
    if (gseen.size() == 2) begin
      chk("t6 first grant", 32'(gseen[0]), 32'd1);
      chk("t6 second grant", 32'(gseen[1]), 32'd2);
    end else begin
      $display("FAIL t6 grant list: got %0d grants, want 2", gseen.size());
      n_bad++;
    end

    // Saturation of the abort counter
    @(negedge clk);
    force dut.abort_cnt_r = 16'hFFFF;
    @(negedge clk);
    release dut.abort_cnt_r;
    @(negedge clk);
    chk("t7 preset", 32'(abort_cnt), 32'hFFFF);
    push_byte(0, 8'h71, 1'b0, 1'b1);
    push_abort();
    push_idle(0, 20);
    push_byte(0, 8'h72, 1'b0, 1'b0);
    push_byte(0, 8'h73, 1'b1, 1'b0);
    wait_done("t7");
    chk("t7 abort_cnt sat", 32'(abort_cnt), 32'hFFFF);

    repeat (5) @(negedge clk);
    chk("end scoreboard empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/eth_rx_arbiter.md
Name: eth_rx_arbiter

Overview:
- Frame-atomic round-robin arbiter that shares one downstream byte consumer (host/UART bridge) between P_NUM_REQ frame streams.
- Requesters are the classified outputs of the RX decoder (for-me, broadcast), each fed through its own frame buffer.
- Grants one complete frame at a time. A stall watchdog aborts a stuck frame, flags it to the consumer, then flushes the rest of that frame.

Parameters:
- P_NUM_REQ, 2: number of requesters; legal range 2..8.
- P_TIMEOUT, 1024: maximum consecutive cycles the granted requester may hold req_vld low mid-frame before the frame is aborted; must be at least 2.
- C_CNT_W, localparam $clog2(P_TIMEOUT+1): width of the stall counter.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req_data  in  P_NUM_REQ*8  byte per requester; requester i uses bits [8i+7:8i]
- req_vld  in  P_NUM_REQ  requester byte valid
- req_last  in  P_NUM_REQ  last byte of frame, qualified by req_vld
- req_rdy  out  P_NUM_REQ  byte accepted from requester
- out_data  out  8  byte to consumer
- out_vld  out  1  output byte valid
- out_last  out  1  last byte of frame
- out_err  out  1  qualifies an abort beat
- out_rdy  in  1  consumer ready
- grant  out  P_NUM_REQ  one-hot current owner; all zero when idle
- busy  out  1  state is not IDLE
- abort_cnt  out  16  saturating count of aborted frames

Behaviour:
- Handshakes: a beat transfers when vld and rdy are both high on a clk edge. Requesters must hold data, last and vld stable until accepted.
- Reset values: state IDLE, grant=0, rr_ptr=P_NUM_REQ-1, stall_cnt=0, abort_cnt=0. All outputs are 0.
- State IDLE:
  - If any req_vld is set, pick the first set bit searching from rr_ptr+1, wrapping modulo P_NUM_REQ.
  - Register grant, set rr_ptr to the winner, go to XFER.
  - Latency is exactly 1 cycle from req_vld to grant. No byte transfers in IDLE.
- State XFER (owner g): combinational pass-through.
  - out_data = req_data[g], out_vld = req_vld[g], out_last = req_last[g], out_err = 0.
  - req_rdy[g] = out_rdy; every other req_rdy bit is 0.
  - An accepted beat with req_last set goes to IDLE, and grant clears on that edge.
  - A new arbitration happens in the following IDLE cycle, so there is a minimum 1-cycle gap between frames.
- Stall counter:
  - Increments each cycle the state is XFER or FLUSH and req_vld[g]=0.
  - Clears on any cycle req_vld[g]=1, and on every state change.
  - Back-pressure (out_rdy=0) never counts toward the timeout.
- Timeout: when stall_cnt reaches P_TIMEOUT-1 while req_vld[g]=0, go to ABORT on the next edge.
- State ABORT:
  - Drive out_vld=1, out_last=1, out_err=1, out_data=8'h00. All req_rdy are 0.
  - Hold until out_rdy. When accepted, abort_cnt increments (saturating at 16'hFFFF) and the state goes to FLUSH.
- State FLUSH:
  - req_rdy[g]=1 and out_vld=0; bytes from the owner are discarded.
  - An accepted req_last goes to IDLE.
  - A second timeout in FLUSH goes directly to IDLE, with no additional abort beat and no abort_cnt increment.
- Boundary conditions:
  - A single-byte frame (vld and last on the first beat) is legal.
  - Requests from non-owners are ignored until IDLE.
  - With all requesters continuously requesting, grants strictly rotate 0,1,..,N-1,0.
  - rr_ptr updates only on a grant.
- Reset mid-frame: everything returns to reset values immediately. The downstream consumer sees a truncated frame without last, and must discard on its own reset.

Decomposition:
- Shared package eth_pkg: state encoding constants C_IDLE, C_XFER, C_ABORT, C_FLUSH (2 bits), and the abort filler byte C_ABORT_BYTE=8'h00.
- One sub-module, rr_pick: combinational round-robin priority picker.
  - Inputs: request vector and pointer.
  - Outputs: one-hot winner, index, and any.
  - Instantiated once.

Test Plan:
- Requester 0 sends a 4-byte frame 0x11,0x22,0x33,0x44 (last on 0x44), out_rdy=1 -> grant=01 one cycle after vld; out shows the 4 bytes with out_last on 0x44; grant=00 after that edge.
- Both requesters continuously present 2-byte frames -> grant sequence 01,10,01,10, with a 1-cycle IDLE gap between frames.
- Owner sends 1 byte, then holds vld low for P_TIMEOUT cycles -> abort beat (vld/last/err=1, data 0x00); abort_cnt=1. The owner's remaining 3 bytes are accepted with out_vld=0, then IDLE.
- out_rdy low for 5000 cycles mid-frame -> no abort; data and req_rdy are held, and the frame completes intact.
- Assert rst_n low while grant=10 mid-frame -> grant=0, busy=0 and out_vld=0 asynchronously. The next arbitration favours requester 0.
- Force abort_cnt to 16'hFFFF and cause one more timeout -> abort_cnt remains 16'hFFFF.
